// File: rtl/ble_packet_deframer.sv
// BLE bit-level deframer: access-address search with Hamming tolerance,
// dewhitening, LSB-first byte assembly and header/payload/CRC framing.
module ble_packet_deframer #(
  parameter logic [31:0] ACCESS_ADDR = 32'h8E89BED6,
  parameter int          MAX_ERR     = 0,
  parameter int          CRC_BYTES   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       update,
  input  logic       data,
  input  logic [5:0] chan,
  input  logic       whiten_en,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic [8:0] byte_idx,
  output logic [7:0] pkt_len,
  output logic       aa_match,
  output logic       pkt_done,
  output logic       busy
);

  localparam logic [1:0] S_SEARCH  = 2'd0;
  localparam logic [1:0] S_HEADER  = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        update_q, update_d;
  logic [31:0] sr_q, sr_d;
  logic [5:0]  fill_q, fill_d;
  logic        hit_q, hit_d;
  logic [6:0]  lfsr_q, lfsr_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [8:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  byte_out_q, byte_out_d;
  logic        byte_valid_q, byte_valid_d;
  logic [8:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  pkt_len_q, pkt_len_d;
  logic        aa_match_q, aa_match_d;
  logic        pkt_done_q, pkt_done_d;

  logic        bit_ev;
  logic        hit_go;
  logic        in_frame;
  logic [31:0] diff;
  logic [5:0]  errs;
  logic        aa_hit;
  logic [6:0]  seed;
  logic [6:0]  lfsr_b;
  logic [6:0]  lfsr_n;
  logic [7:0]  shreg_b;
  logic [7:0]  shreg_n;
  logic [2:0]  bcnt_b;
  logic [8:0]  byte_cnt_b;
  logic        w;
  logic        dbit;
  logic [7:0]  len_n;
  logic [8:0]  n_last;

  assign bit_ev = update & ~update_q;
  assign seed   = {1'b1, chan};
  assign diff   = sr_q ^ ACCESS_ADDR;

  always_comb begin
    errs = '0;
    for (int i = 0; i < 32; i++) begin
      errs = errs + {5'd0, diff[i]};
    end
  end

  assign aa_hit = (fill_q == 6'd32) && (errs <= 6'(MAX_ERR));

  // A bit landing on the match cycle is the first header bit, seeded directly.
  assign hit_go   = (state_q == S_SEARCH) & hit_q;
  assign in_frame = (state_q != S_SEARCH) | hit_go;

  assign lfsr_b     = hit_go ? seed : lfsr_q;
  assign shreg_b    = hit_go ? 8'd0 : shreg_q;
  assign bcnt_b     = hit_go ? 3'd0 : bcnt_q;
  assign byte_cnt_b = hit_go ? 9'd0 : byte_cnt_q;

  assign w       = lfsr_b[0];
  assign lfsr_n  = {w, lfsr_b[6:4], lfsr_b[3] ^ w, lfsr_b[2:1]};
  assign dbit    = data ^ (w & whiten_en);
  assign shreg_n = {dbit, shreg_b[7:1]};

  // Last byte index uses the length byte itself when it is the byte closing.
  assign len_n  = (byte_cnt_b == 9'd1) ? shreg_n : pkt_len_q;
  assign n_last = 9'd1 + {1'b0, len_n} + 9'(CRC_BYTES);

  always_comb begin
    state_d      = state_q;
    update_d     = update;
    sr_d         = sr_q;
    fill_d       = fill_q;
    hit_d        = 1'b0;
    lfsr_d       = lfsr_q;
    shreg_d      = shreg_q;
    bcnt_d       = bcnt_q;
    byte_cnt_d   = byte_cnt_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    byte_idx_d   = byte_idx_q;
    pkt_len_d    = pkt_len_q;
    aa_match_d   = 1'b0;
    pkt_done_d   = 1'b0;

    if (!enable) begin
      state_d    = S_SEARCH;
      update_d   = 1'b0;
      sr_d       = '0;
      fill_d     = '0;
      lfsr_d     = '0;
      shreg_d    = '0;
      bcnt_d     = '0;
      byte_cnt_d = '0;
    end else begin
      hit_d = (state_q == S_SEARCH) & aa_hit & ~hit_go;

      if (hit_go) begin
        state_d    = S_HEADER;
        aa_match_d = 1'b1;
        lfsr_d     = seed;
        shreg_d    = '0;
        bcnt_d     = '0;
        byte_cnt_d = '0;
      end

      if ((state_q == S_SEARCH) && !hit_go && bit_ev) begin
        sr_d = {data, sr_q[31:1]};
        if (fill_q != 6'd32) begin
          fill_d = fill_q + 6'd1;
        end
      end

      if (in_frame && bit_ev) begin
        lfsr_d  = lfsr_n;
        shreg_d = shreg_n;
        bcnt_d  = bcnt_b + 3'd1;
        if (bcnt_b == 3'd7) begin
          byte_out_d   = shreg_n;
          byte_valid_d = 1'b1;
          byte_idx_d   = byte_cnt_b;
          byte_cnt_d   = byte_cnt_b + 9'd1;
          if (byte_cnt_b == 9'd1) begin
            pkt_len_d = shreg_n;
          end
          if (byte_cnt_b == n_last) begin
            pkt_done_d = 1'b1;
            state_d    = S_SEARCH;
            sr_d       = '0;
            fill_d     = '0;
          end else if (byte_cnt_b == 9'd1) begin
            state_d = S_PAYLOAD;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_SEARCH;
      update_q     <= 1'b0;
      sr_q         <= '0;
      fill_q       <= '0;
      hit_q        <= 1'b0;
      lfsr_q       <= '0;
      shreg_q      <= '0;
      bcnt_q       <= '0;
      byte_cnt_q   <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_idx_q   <= '0;
      pkt_len_q    <= '0;
      aa_match_q   <= 1'b0;
      pkt_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      update_q     <= update_d;
      sr_q         <= sr_d;
      fill_q       <= fill_d;
      hit_q        <= hit_d;
      lfsr_q       <= lfsr_d;
      shreg_q      <= shreg_d;
      bcnt_q       <= bcnt_d;
      byte_cnt_q   <= byte_cnt_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      byte_idx_q   <= byte_idx_d;
      pkt_len_q    <= pkt_len_d;
      aa_match_q   <= aa_match_d;
      pkt_done_q   <= pkt_done_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign byte_idx   = byte_idx_q;
  assign pkt_len    = pkt_len_q;
  assign aa_match   = aa_match_q;
  assign pkt_done   = pkt_done_q;
  assign busy       = (state_q != S_SEARCH);

endmodule

// File: tb/tb_ble_packet_deframer.sv
// Directed bench for ble_packet_deframer; three instances differ
// only in Hamming tolerance (0, 1, 2).
module tb_ble_packet_deframer;

  localparam logic [31:0] AA = 32'h8E89BED6;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       update;
  logic       data;
  logic [5:0] chan;
  logic       whiten_en;

  logic [7:0] bo [3];
  logic       bv [3];
  logic [8:0] bi [3];
  logic [7:0] pl [3];
  logic       am [3];
  logic       pd [3];
  logic       by [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ble_packet_deframer #(
      .ACCESS_ADDR(AA),
      .MAX_ERR    (g),
      .CRC_BYTES  (3)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .update    (update),
      .data      (data),
      .chan      (chan),
      .whiten_en (whiten_en),
      .byte_out  (bo[g]),
      .byte_valid(bv[g]),
      .byte_idx  (bi[g]),
      .pkt_len   (pl[g]),
      .aa_match  (am[g]),
      .pkt_done  (pd[g]),
      .busy      (by[g])
    );
  end

  int         nb = 0;
  int         nd = 0;
  int         done_idx = -1;
  int         busy_done = -1;
  int         na [3] = '{0, 0, 0};
  logic [7:0] rb [256];
  int         ri [256];

  always @(negedge clk) begin
    if (bv[0] && nb < 256) begin
      rb[nb] <= bo[0];
      ri[nb] <= int'(bi[0]);
      nb     <= nb + 1;
    end
    if (pd[0]) begin
      nd        <= nd + 1;
      done_idx  <= int'(bi[0]);
      busy_done <= int'(by[0]);
    end
    for (int k = 0; k < 3; k++) begin
      if (am[k]) na[k] <= na[k] + 1;
    end
  end

  int ntot = 0;
  int npass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  logic [7:0] pk [7] = '{8'h00, 8'h02, 8'hAA, 8'h55, 8'h11, 8'h22, 8'h33};

  task automatic send_bit(input logic b, input int hold);
    @(negedge clk);
    data   = b;
    update = 1'b1;
    repeat (hold) @(negedge clk);
    update = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] wd, input int hold);
    for (int i = 0; i < 32; i++) send_bit(wd[i], hold);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    for (int i = 0; i < 8; i++) send_bit(b[i], hold);
  endtask

  task automatic send_pkt(input int hold);
    send_word(AA, hold);
    for (int i = 0; i < 7; i++) send_byte(pk[i], hold);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic dis();
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic chk_pkt(input string tag, input int b0, input int d0);
    chk({tag, "_nbytes"}, 32'(nb - b0), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (b0 + i < 256) begin
        chk({tag, "_byte"}, 32'(rb[b0 + i]), 32'(pk[i]));
        chk({tag, "_idx"}, 32'(ri[b0 + i]), 32'(i));
      end
    end
    chk({tag, "_done"}, 32'(nd - d0), 32'd1);
    chk({tag, "_done_idx"}, 32'(done_idx), 32'd6);
    chk({tag, "_busy_at_done"}, 32'(busy_done), 32'd0);
    chk({tag, "_pkt_len"}, 32'(pl[0]), 32'd2);
    chk({tag, "_busy_after"}, 32'(by[0]), 32'd0);
  endtask

  int b0, d0, a0, a1, a2;
  logic [31:0] pre;

  initial begin
    rst = 1'b0; enable = 1'b0; update = 1'b0; data = 1'b0;
    chan = 6'd0; whiten_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_byte_out", 32'(bo[0]), 0);
    chk("rst_byte_valid", 32'(bv[0]), 0);
    chk("rst_byte_idx", 32'(bi[0]), 0);
    chk("rst_pkt_len", 32'(pl[0]), 0);
    chk("rst_aa_match", 32'(am[0]), 0);
    chk("rst_pkt_done", 32'(pd[0]), 0);
    chk("rst_busy", 32'(by[0]), 0);
    rst = 1'b1;
    enable = 1'b1;

    // basic packet at minimum bit spacing
    b0 = nb; d0 = nd; a0 = na[0];
    send_pkt(1);
    settle();
    chk("basic_aa", 32'(na[0] - a0), 1);
    chk_pkt("basic", b0, d0);

    // two flipped address bits against tolerance 0/1/2
    dis();
    a0 = na[0]; a1 = na[1]; a2 = na[2];
    send_word(AA ^ 32'h0001_0100, 1);
    settle();
    chk("flip2_err0", 32'(na[0] - a0), 0);
    chk("flip2_err1", 32'(na[1] - a1), 0);
    chk("flip2_err2", 32'(na[2] - a2), 1);
    chk("flip2_busy2", 32'(by[2]), 1);

    // whitening, chan 37: raw 0xFF dewhitens to 0x72
    dis();
    whiten_en = 1'b1; chan = 6'd37;
    b0 = nb;
    send_word(AA, 1);
    send_byte(8'hFF, 1);
    settle();
    chk("wh_nbytes", 32'(nb - b0), 1);
    chk("wh_byte", 32'(rb[b0]), 32'h72);
    chk("wh_bit0", 32'(rb[b0][0]), 0);
    chk("wh_bit1", 32'(rb[b0][1]), 1);
    chk("wh_idx", 32'(ri[b0]), 0);
    whiten_en = 1'b0; chan = 6'd0;

    // long update pulses: one bit per rising edge
    dis();
    b0 = nb; d0 = nd; a0 = na[0];
    send_pkt(10);
    settle();
    chk("hold_aa", 32'(na[0] - a0), 1);
    chk_pkt("hold", b0, d0);

    // abort after byte 3, then recover
    dis();
    b0 = nb; d0 = nd;
    send_word(AA, 1);
    for (int i = 0; i < 4; i++) send_byte(pk[i], 1);
    settle();
    chk("abort_nbytes_pre", 32'(nb - b0), 4);
    chk("abort_busy_pre", 32'(by[0]), 1);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("abort_busy", 32'(by[0]), 0);
    for (int i = 4; i < 7; i++) send_byte(pk[i], 1);
    settle();
    chk("abort_nbytes", 32'(nb - b0), 4);
    chk("abort_done", 32'(nd - d0), 0);
    chk("abort_pkt_len", 32'(pl[0]), 2);
    enable = 1'b1;
    b0 = nb; d0 = nd;
    send_pkt(1);
    settle();
    chk_pkt("resend", b0, d0);

    // sr equals the address after 31 bits, but fill is short
    dis();
    a0 = na[0];
    pre = AA >> 1;
    for (int i = 0; i < 31; i++) send_bit(pre[i], 1);
    settle();
    chk("fill31_nomatch", 32'(na[0] - a0), 0);
    chk("fill31_busy", 32'(by[0]), 0);
    b0 = nb; d0 = nd;
    send_pkt(1);
    settle();
    chk("fill_true_aa", 32'(na[0] - a0), 1);
    chk_pkt("fill", b0, d0);

    // asynchronous reset mid-packet
    dis();
    send_word(AA, 1);
    send_byte(8'h00, 1);
    send_byte(8'h02, 1);
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    @(negedge clk);
    #3;
    chk("pre_arst_busy", 32'(by[0]), 1);
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(by[0]), 0);
    chk("arst_pkt_len", 32'(pl[0]), 0);
    chk("arst_byte_idx", 32'(bi[0]), 0);
    chk("arst_byte_out", 32'(bo[0]), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/ble_packet_deframer.md
# ble_packet_deframer

Bit-level packet deframer downstream of the matched filter / timing recovery pair. Consumes one demodulated bit per `update` strobe and searches for a programmable 32-bit access address with Hamming tolerance. On a match it dewhitens the following bits, assembles LSB-first bytes and frames one packet: 2 header bytes, then `length` payload bytes, then CRC bytes. Output is a byte stream with per-byte valid strobes for the CRC checker / packet buffer.

## Interface
- `ACCESS_ADDR`, 32'h8E89BED6, access address, transmitted LSB first
- `MAX_ERR`, 0, maximum bit mismatches accepted for an access-address match (0..31)
- `CRC_BYTES`, 3, trailing bytes framed after the payload
- `clk`  in  1  system clock (16 MHz)
- `rst`  in  1  reset, asynchronous, active-low
- `enable`  in  1  deframer run; low forces SEARCH and clears state
- `update`  in  1  bit strobe from timing recovery; a bit is taken on its rising edge only
- `data`  in  1  demodulated bit
- `chan`  in  6  channel index, whitening seed
- `whiten_en`  in  1  1 = dewhiten header/payload/CRC bits
- `byte_out`  out  8  assembled byte, first received bit in bit 0
- `byte_valid`  out  1  one-cycle strobe, `byte_out`/`byte_idx` valid
- `byte_idx`  out  9  index of the byte within the packet (header byte 0 = 0)
- `pkt_len`  out  8  payload length (header byte 1), held until the next match
- `aa_match`  out  1  one-cycle pulse on access-address detection
- `pkt_done`  out  1  one-cycle pulse coincident with the last byte's `byte_valid`
- `busy`  out  1  high in HEADER or PAYLOAD

## Operation
- Bit event: `bit_ev = update & ~update_q`, with `update_q` registered every clk. `update` held high yields exactly one bit.
- SEARCH: `sr <= {data, sr[31:1]}` on each bit_ev. A 6-bit fill counter saturates at 32. A match requires fill == 32 and popcount(`sr` ^ `ACCESS_ADDR`) <= `MAX_ERR`, both evaluated on the registered `sr`. On a match: pulse `aa_match`, load LFSR, clear byte/bit counters, go to HEADER.
- Whitening LFSR, 7 bits: seed = {1'b1, chan[5:0]}. Per bit, w = lfsr[0]. The next state is {w, lfsr[6:1]} with bit 2 replaced by lfsr[3]^w. The LFSR steps only on bit_ev in HEADER/PAYLOAD. The dewhitened bit is `data ^ (w & whiten_en)`.
- Byte assembly: `shreg <= {dbit, shreg[7:1]}`, 3-bit bit counter. On the 8th bit, register `byte_out` and the current `byte_idx`, then increment the byte counter.
- HEADER: bytes 0 and 1. Byte 1 is latched to `pkt_len`, then go to PAYLOAD.
- PAYLOAD: total packet bytes N = 2 + pkt_len + CRC_BYTES (9-bit, max 260). On the byte with index N-1, pulse `pkt_done`, return to SEARCH, and clear `sr` and the fill counter.
- `enable` low in any state: next clk goes to SEARCH, clears counters, `sr`, fill and `update_q` history. No `pkt_done` is produced for the aborted packet. `pkt_len` is retained.
- Match is tested only in SEARCH. Bits arriving in HEADER/PAYLOAD never retrigger a match.

## Timing
- Reset values: `byte_out`=0, `byte_valid`=0, `byte_idx`=0, `pkt_len`=0, `aa_match`=0, `pkt_done`=0, `busy`=0, state SEARCH, `sr`=0, fill=0, lfsr=0, `update_q`=0.
- `aa_match` asserts 2 clk after the rising clk that sampled the 32nd bit's `update` edge (1 cycle to shift, 1 cycle for compare register). Bits arriving within that window are buffered: the first header bit is the first bit_ev after the 32nd.
- `byte_valid` asserts 1 clk after the bit_ev of the byte's 8th bit. `busy` drops in the same cycle as `pkt_done`.
- Minimum bit spacing is 2 clk. Closer bit_ev spacing is unsupported.
- `rst` asserted mid-packet: all outputs go to reset values immediately (asynchronous).

## Test plan
- Feed 0x8E89BED6 LSB first with `whiten_en`=0 and `MAX_ERR`=0, then header 0x00,0x02, payload 0xAA,0x55 and CRC 0x11,0x22,0x33 -> one `aa_match`; 7 `byte_valid` with bytes 00,02,AA,55,11,22,33 at idx 0..6; `pkt_len`=2; `pkt_done` on idx 6.
- Same address with 2 flipped bits: `MAX_ERR`=1 -> no `aa_match`; `MAX_ERR`=2 -> `aa_match`.
- `whiten_en`=1, `chan`=37: first two header bits received as 1,1 -> dewhitened bits 0,1 (w sequence 1,0).
- Hold `update` high for 10 clk per bit -> exactly one bit per pulse; same bytes as the first test.
- Drop `enable` after byte idx 3 -> no further `byte_valid`, no `pkt_done`, `busy`=0. Re-enable and resend the packet -> normal framing.
- Random bits for 31 bits after reset, then the address -> no false match before fill=32; `aa_match` only on the true address.
